// File: rtl/servo_ramp_sequencer_pkg.sv
// Shared definitions for the servo ramp sequencer: register offsets, CTRL bit positions,
// FSM state encoding and the single-LSB step helper.
package servo_ramp_sequencer_pkg;

  // Register offsets relative to BASE_ADDRESS
  localparam logic [1:0] OffCtrl   = 2'd0;
  localparam logic [1:0] OffTarget = 2'd1;
  localparam logic [1:0] OffRate   = 2'd2;
  localparam logic [1:0] OffPos    = 2'd3;

  // CTRL write bits
  localparam int unsigned CtrlGoBit    = 0;
  localparam int unsigned CtrlAbortBit = 1;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRamp = 1'b1
  } state_e;

  // One LSB toward tgt; callers only use it when pos != tgt, so it never wraps.
  function automatic logic [7:0] step_toward(input logic [7:0] pos, input logic [7:0] tgt);
    return (tgt > pos) ? (pos + 8'd1) : (pos - 8'd1);
  endfunction

endpackage

// File: rtl/servo_ramp_sequencer_if.sv
// Shared CPU I/O bus used by the servo ramp sequencer.
//   din     : write data (master -> slave)
//   address : register address (master -> slave)
//   w_en    : 1-cycle write strobe
//   r_en    : 1-cycle read strobe
//   dout    : registered read data (slave -> master), valid the cycle after r_en
interface servo_ramp_sequencer_if;
  logic [7:0] din;
  logic [7:0] address;
  logic       w_en;
  logic       r_en;
  logic [7:0] dout;

  modport master (output din, output address, output w_en, output r_en, input dout);
  modport slave  (input din, input address, input w_en, input r_en, output dout);
endinterface

// File: rtl/servo_tick_gen.sv
// Free-running timebase: a prescaler counts 0..CLK_FREQ/TICK_HZ-1 and tick is high for the
// single cycle in which it sits at its terminal count.
//   clk  : system clock
//   rst  : synchronous active-high reset (prescaler to 0)
//   tick : one-cycle pulse at TICK_HZ
module servo_tick_gen #(
  parameter int unsigned CLK_FREQ = 16000000,
  parameter int unsigned TICK_HZ  = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned TickDiv = CLK_FREQ / TICK_HZ;
  localparam int unsigned CntW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TickDiv - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    tick  = (cnt_q == CntMax);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/servo_ramp_sequencer.sv
// Bus-mapped motion controller in front of the servo PWM peripheral. The CPU writes a target
// and a rate (ms per LSB); the block walks pos_out one LSB per rate ticks toward the target,
// pulsing pos_we on every change.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   bus     : register bus (slave side): CTRL +0, TARGET +1, RATE +2, POS +3
//   pos_out : current commanded position
//   pos_we  : 1-cycle pulse whenever pos_out changes
//   busy    : high while ramping
module servo_ramp_sequencer
  import servo_ramp_sequencer_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDRESS = 8'h00,
  parameter int unsigned CLK_FREQ     = 16000000
) (
  input  logic                          clk,
  input  logic                          rst,
  servo_ramp_sequencer_if.slave         bus,
  output logic [7:0]                    pos_out,
  output logic                          pos_we,
  output logic                          busy
);

  logic tick;

  servo_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .TICK_HZ  (1000)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  state_e     state_q, state_d;
  logic [7:0] pos_q, pos_d;
  logic [7:0] target_q, target_d;
  logic [7:0] rate_q, rate_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] dout_q, dout_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       pos_we_q, pos_we_d;

  logic [7:0] offset;
  logic       hit;
  logic [1:0] sel;
  logic       wr_ctrl, wr_target, wr_rate, wr_pos, rd_ctrl;
  logic       go, abort;
  logic [8:0] cnt_inc;
  logic [7:0] next_pos;

  always_comb begin
    offset    = bus.address - BASE_ADDRESS;
    hit       = (offset < 8'd4);
    sel       = offset[1:0];
    wr_ctrl   = bus.w_en && hit && (sel == OffCtrl);
    wr_target = bus.w_en && hit && (sel == OffTarget);
    wr_rate   = bus.w_en && hit && (sel == OffRate);
    wr_pos    = bus.w_en && hit && (sel == OffPos);
    rd_ctrl   = bus.r_en && hit && (sel == OffCtrl);
    // ABORT wins over GO when both are written together
    abort     = wr_ctrl && bus.din[CtrlAbortBit];
    go        = wr_ctrl && bus.din[CtrlGoBit] && !bus.din[CtrlAbortBit];
    cnt_inc   = {1'b0, cnt_q} + 9'd1;
    next_pos  = step_toward(pos_q, target_q);
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    target_d = target_q;
    rate_d   = rate_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    done_d   = done_q;
    pos_we_d = 1'b0;

    if (bus.r_en) begin
      if (!hit) begin
        dout_d = '0;
      end else begin
        unique case (sel)
          OffCtrl:   dout_d = {6'b0, done_q, busy_q};
          OffTarget: dout_d = target_q;
          OffRate:   dout_d = rate_q;
          OffPos:    dout_d = pos_q;
        endcase
      end
    end
    // Read-clear first so any FSM set below takes priority
    if (rd_ctrl) done_d = 1'b0;

    if (wr_target) target_d = bus.din;
    if (wr_rate)   rate_d   = bus.din;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          if (pos_q == target_q) begin
            done_d = 1'b1;
          end else begin
            state_d = StRamp;
            done_d  = 1'b0;
            cnt_d   = '0;
          end
        end
        if (wr_pos) begin
          pos_d    = bus.din;
          pos_we_d = 1'b1;
        end
      end
      StRamp: begin
        if (abort) begin
          state_d = StIdle;
        end else if ((wr_target && (bus.din == pos_q)) || (pos_q == target_q)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (rate_q == 8'd0) begin
          pos_d    = target_q;
          pos_we_d = 1'b1;
          state_d  = StIdle;
          done_d   = 1'b1;
        end else if (tick) begin
          // >= so a RATE lowered below the running count steps on the next tick
          if (cnt_inc >= {1'b0, rate_q}) begin
            cnt_d    = '0;
            pos_d    = next_pos;
            pos_we_d = 1'b1;
            if (next_pos == target_q) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc[7:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StRamp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pos_q    <= '0;
      target_q <= '0;
      rate_q   <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      pos_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      target_q <= target_d;
      rate_q   <= rate_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      pos_we_q <= pos_we_d;
    end
  end

  assign bus.dout = dout_q;
  assign pos_out  = pos_q;
  assign pos_we   = pos_we_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_servo_ramp_sequencer.sv
// Bench for servo_ramp_sequencer at CLK_FREQ=16000 (16 clocks per 1 ms tick). Expected step
// sequences are built as lists of positions; consecutive steps must be 16*rate clocks apart.
module tb_servo_ramp_sequencer;

  localparam logic [7:0] ACtrl   = 8'h00;
  localparam logic [7:0] ATarget = 8'h01;
  localparam logic [7:0] ARate   = 8'h02;
  localparam logic [7:0] APos    = 8'h03;
  localparam int TickClk = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pos_out;
  logic       pos_we;
  logic       busy;
  logic [7:0] rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulse_pos[$];
  int pulse_cyc[$];
  int pulse_busy[$];
  int exp_q[$];

  servo_ramp_sequencer_if bus ();

  servo_ramp_sequencer #(
    .BASE_ADDRESS (8'h00),
    .CLK_FREQ     (16000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .pos_out (pos_out),
    .pos_we  (pos_we),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every position write seen by the servo peripheral
  always @(negedge clk) begin
    if (pos_we === 1'b1) begin
      pulse_pos.push_back(int'(pos_out));
      pulse_cyc.push_back(cyc);
      pulse_busy.push_back(int'(busy));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.address = a;
    bus.din     = d;
    bus.w_en    = 1'b1;
    step(1);
    bus.w_en    = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    bus.address = a;
    bus.r_en    = 1'b1;
    step(1);
    bus.r_en    = 1'b0;
    d = bus.dout;
  endtask

  task automatic clear_pulses();
    pulse_pos.delete();
    pulse_cyc.delete();
    pulse_busy.delete();
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while (busy === 1'b1 && n < max) begin
      step(1);
      n++;
    end
    check(tag, {31'b0, busy}, 32'd0);
    step(1);
  endtask

  task automatic wait_pos(input logic [7:0] v, input int max, input string tag);
    int n = 0;
    while (pos_out !== v && n < max) begin
      step(1);
      n++;
    end
    check(tag, {24'b0, pos_out}, {24'b0, v});
  endtask

  // Compare recorded pulses with exp_q; end_idle means the last step also ends the ramp
  task automatic expect_pulses(input string tag, input int rate, input bit end_idle);
    int n;
    check($sformatf("%s_count", tag), pulse_pos.size(), exp_q.size());
    n = (pulse_pos.size() < exp_q.size()) ? pulse_pos.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_pos%0d", tag, i), pulse_pos[i], exp_q[i]);
      check($sformatf("%s_busy%0d", tag, i), pulse_busy[i],
            (end_idle && i == exp_q.size() - 1) ? 0 : 1);
      if (rate > 0 && i > 0)
        check($sformatf("%s_gap%0d", tag, i), pulse_cyc[i] - pulse_cyc[i-1], TickClk * rate);
    end
  endtask

  initial begin
    bus.din     = '0;
    bus.address = '0;
    bus.w_en    = 1'b0;
    bus.r_en    = 1'b0;

    // 1. Reset
    step(2);
    rst = 1'b0;
    check("rst_pos", pos_out, 0);
    check("rst_busy", busy, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_we", pos_we, 0);
    rd(ACtrl, rdata);
    check("rst_ctrl", rdata, 8'h00);

    // 2. Up-ramp 0 -> 5 at 2 ms/LSB
    wr(ATarget, 8'd5);
    wr(ARate, 8'd2);
    step(1);
    clear_pulses();
    wr(ACtrl, 8'h01);
    check("up_busy", busy, 1);
    wait_idle(TickClk * 2 * 7, "up_idle");
    exp_q.delete();
    for (int s = 1; s <= 5; s++) exp_q.push_back(s);
    expect_pulses("up", 2, 1'b1);
    rd(ACtrl, rdata);
    check("up_ctrl", rdata, 8'h02);
    rd(ACtrl, rdata);
    check("up_ctrl_clr", rdata, 8'h00);

    // 3. Jump with RATE=0, then down-ramp
    wr(APos, 8'd200);
    wr(ATarget, 8'd10);
    wr(ARate, 8'd0);
    step(1);
    clear_pulses();
    wr(ACtrl, 8'h01);
    wait_idle(10, "jump_idle");
    exp_q.delete();
    exp_q.push_back(10);
    expect_pulses("jump", 0, 1'b1);
    rd(ACtrl, rdata);
    check("jump_ctrl", rdata, 8'h02);
    wr(ATarget, 8'd7);
    wr(ARate, 8'd1);
    step(1);
    clear_pulses();
    wr(ACtrl, 8'h01);
    wait_idle(TickClk * 5, "down_idle");
    exp_q.delete();
    for (int s = 9; s >= 7; s--) exp_q.push_back(s);
    expect_pulses("down", 1, 1'b1);

    // Randomized ramps against the position-list model
    for (int k = 0; k < 3; k++) begin
      int p0, dl, t, r;
      p0 = int'($urandom_range(20, 230));
      dl = int'($urandom_range(1, 10));
      r  = int'($urandom_range(1, 3));
      t  = ($urandom_range(0, 1) == 1) ? p0 + dl : p0 - dl;
      wr(APos, 8'(p0));
      wr(ATarget, 8'(t));
      wr(ARate, 8'(r));
      step(1);
      clear_pulses();
      wr(ACtrl, 8'h01);
      wait_idle(TickClk * r * (dl + 2), $sformatf("rnd%0d_idle", k));
      exp_q.delete();
      for (int s = 1; s <= dl; s++) exp_q.push_back((t > p0) ? p0 + s : p0 - s);
      expect_pulses($sformatf("rnd%0d", k), r, 1'b1);
      rd(ACtrl, rdata);
      check($sformatf("rnd%0d_ctrl", k), rdata, 8'h02);
    end

    // 4. Retarget on the fly: 0 -> 100, redirected to 15 at position 20
    wr(APos, 8'd0);
    wr(ATarget, 8'd100);
    wr(ARate, 8'd1);
    step(1);
    clear_pulses();
    wr(ACtrl, 8'h01);
    wait_pos(8'd20, TickClk * 25, "rt_reach20");
    wr(ATarget, 8'd15);
    wait_idle(TickClk * 10, "rt_idle");
    exp_q.delete();
    for (int s = 1; s <= 20; s++) exp_q.push_back(s);
    for (int s = 19; s >= 15; s--) exp_q.push_back(s);
    expect_pulses("rt", 1, 1'b1);
    rd(ACtrl, rdata);
    check("rt_ctrl", rdata, 8'h02);

    // 5. Abort, GO+ABORT, POS write while ramping
    wr(APos, 8'd0);
    wr(ATarget, 8'd50);
    step(1);
    wr(ACtrl, 8'h01);
    wait_pos(8'd3, TickClk * 5, "ab_reach3");
    wr(ACtrl, 8'h02);
    check("ab_busy", busy, 0);
    check("ab_pos", pos_out, 3);
    step(1);
    clear_pulses();
    wr(ACtrl, 8'h03);
    check("goab_busy", busy, 0);
    step(40);
    check("goab_pos", pos_out, 3);
    check("goab_pulses", pulse_pos.size(), 0);
    rd(ACtrl, rdata);
    check("ab_ctrl", rdata, 8'h00);
    clear_pulses();
    wr(ACtrl, 8'h01);
    wr(APos, 8'd123);
    wait_pos(8'd6, TickClk * 5, "pw_reach6");
    wr(ACtrl, 8'h02);
    step(1);
    exp_q.delete();
    for (int s = 4; s <= 6; s++) exp_q.push_back(s);
    expect_pulses("pw", 1, 1'b0);

    // 6. Bus decode and reset mid-ramp
    rd(ATarget, rdata);
    check("rd_target", rdata, 8'd50);
    rd(8'h40, rdata);
    check("rd_unmapped", rdata, 8'h00);
    wr(ATarget, 8'd200);
    step(1);
    wr(ACtrl, 8'h01);
    wait_pos(8'd10, TickClk * 6, "rst_reach10");
    step(4);
    clear_pulses();
    rst = 1'b1;
    step(1);
    check("mrst_pos", pos_out, 0);
    check("mrst_busy", busy, 0);
    check("mrst_we", pos_we, 0);
    step(1);
    rst = 1'b0;
    step(40);
    check("mrst_pulses", pulse_pos.size(), 0);
    check("mrst_pos_after", pos_out, 0);
    rd(ACtrl, rdata);
    check("mrst_ctrl", rdata, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
